// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8-bit UART receiver, 2-flop input synchronizer, mid-bit sampling at fixed latency.
// Optional even parity between data and stop bits: define UART_RX_PARITY_EN.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    logic [1:0]    r_sync;
    logic          r_rx_prev;
    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data_out;
    logic          r_data_valid;
    logic          r_frame_err;

    logic          w_rx_s;
    logic          w_fall;
    logic          w_tick;
    logic          w_stop_point;
    logic          w_parity_ok;

    assign w_rx_s = r_sync[1];
    assign w_fall = r_rx_prev & ~w_rx_s;

    // START waits half a bit to land mid-bit; every later sample is a full bit apart.
    assign w_tick = (r_state == ST_START) ? (r_timer == HALF_LAST)
                                          : (r_timer == BIT_LAST);

    assign w_stop_point = ena && (r_state == ST_STOP) && w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rx_prev <= r_sync[1];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    w_state_next = w_rx_s ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (w_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (!ena) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Timer idles at zero so entering START starts counting from a clean value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (!ena || w_tick || (r_state == ST_IDLE) || (r_state == ST_BREAK)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_idx <= 3'd0;
        end else if (!ena || (r_state == ST_IDLE)) begin
            r_bit_idx <= 3'd0;
        end else if ((r_state == ST_DATA) && w_tick) begin
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= 8'h00;
        end else if (ena && (r_state == ST_DATA) && w_tick) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bit <= 1'b0;
        end else if (ena && (r_state == ST_PARITY) && w_tick) begin
            r_par_bit <= w_rx_s;
        end
    end

    assign w_parity_ok = (r_par_bit == ^r_shift);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_stop_point && !w_parity_ok;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign w_parity_ok = 1'b1;
    assign parity_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_data_valid <= w_stop_point && w_rx_s && w_parity_ok;
            r_frame_err  <= w_stop_point && !w_rx_s;
            if (w_stop_point && w_rx_s && w_parity_ok) begin
                r_data_out <= r_shift;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Testbench for uart_rx_8n1: directed and random frames checked against a frame-level event model.
module tb_uart_rx_8n1;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Decision edge relative to the start edge at the pin: sync (2) + detect (1) + half bit + full bits to stop.
    localparam int LAT = 3 + CPB / 2 + (NB - 1) * CPB;

    localparam int K_DV = 0;
    localparam int K_FE = 1;
    localparam int K_PE = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    logic [7:0] model_last;
    logic prev_dv = 1'b0;
    logic prev_fe = 1'b0;
    logic prev_pe = 1'b0;

    logic [7:0] d;
    logic       stop_b;
    logic       par_b;
    int         n;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (frame_err === 1'b1) begin
            chk("fe_single_cycle", 32'(prev_fe), 32'(0));
            obs_q.push_back('{cyc, K_FE, 8'h00});
        end
        if (parity_err === 1'b1) begin
            chk("pe_single_cycle", 32'(prev_pe), 32'(0));
            obs_q.push_back('{cyc, K_PE, 8'h00});
        end
        if (data_valid === 1'b1) begin
            chk("dv_single_cycle", 32'(prev_dv), 32'(0));
            obs_q.push_back('{cyc, K_DV, data_out});
        end
        prev_dv = (data_valid === 1'b1);
        prev_fe = (frame_err === 1'b1);
        prev_pe = (parity_err === 1'b1);
    end

    task automatic idle(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    // inj_kind: 0 none, 1 one-cycle reset, 2 ena low until frame end; applied mid-way through bit inj_bit.
    task automatic send_frame(input string tag, input logic [7:0] dat, input logic stop_bit,
                              input logic par_bit, input int inj_kind, input int inj_bit);
        logic [10:0] bits;
        int          s;
        logic        hit;
        logic        par_ok;
        bits       = '1;
        bits[0]    = 1'b0;
        bits[8:1]  = dat;
`ifdef UART_RX_PARITY_EN
        bits[9]    = par_bit;
        par_ok     = (par_bit == ^dat);
`else
        par_ok     = 1'b1;
`endif
        bits[NB-1] = stop_bit;
        s = cyc;
        for (int b = 0; b < NB; b++) begin
            rx = bits[b];
            for (int c = 0; c < CPB; c++) begin
                hit = (inj_kind != 0) && (b == inj_bit) && (c == CPB / 2);
                if (hit) begin
                    if (inj_kind == 1) rst = 1'b1;
                    else ena = 1'b0;
                end
                @(negedge clk);
                if (hit) begin
                    chk({tag, "_busy_abort"}, 32'(busy), 32'(0));
                    if (inj_kind == 1) begin
                        chk({tag, "_rst_data_out"}, 32'(data_out), 32'(0));
                        chk({tag, "_rst_dv"}, 32'(data_valid), 32'(0));
                        rst = 1'b0;
                        model_last = 8'h00;
                    end else begin
                        chk({tag, "_ena_hold"}, 32'(data_out), 32'(model_last));
                    end
                end
            end
        end
        if (inj_kind == 2) ena = 1'b1;
        if (inj_kind == 0) begin
            if (!stop_bit) exp_q.push_back('{s + LAT, K_FE, 8'h00});
            if (!par_ok)   exp_q.push_back('{s + LAT, K_PE, 8'h00});
            if (stop_bit && par_ok) begin
                exp_q.push_back('{s + LAT, K_DV, dat});
                model_last = dat;
            end
        end
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_event_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_event_cycle"}, 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
            chk({tag, "_event_kind"}, 32'(obs_q[i].kind), 32'(exp_q[i].kind));
            chk({tag, "_event_value"}, 32'(obs_q[i].val), 32'(exp_q[i].val));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ena = 1'b1;
        rx  = 1'b1;
        model_last = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_data_out", 32'(data_out), 32'(0));
        chk("reset_dv", 32'(data_valid), 32'(0));
        chk("reset_fe", 32'(frame_err), 32'(0));
        chk("reset_pe", 32'(parity_err), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        idle(5);

        send_frame("a5", 8'hA5, 1'b1, ^8'hA5, 0, 0);
        idle(20);
        check_events("a5");
        chk("a5_data_out", 32'(data_out), 32'(8'hA5));
        chk("a5_busy_after", 32'(busy), 32'(0));

        rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy_set", 32'(busy), 32'(1));
        rx = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("glitch_busy_clear", 32'(busy), 32'(0));
        idle(20);
        check_events("glitch");

        send_frame("3c", 8'h3C, 1'b1, ^8'h3C, 0, 0);
        send_frame("5a_brk", 8'h5A, 1'b0, ^8'h5A, 0, 0);
        repeat (30) @(negedge clk);
        chk("break_busy_held", 32'(busy), 32'(1));
        check_events("3c_5a");
        chk("break_data_out", 32'(data_out), 32'(8'h3C));
        rx = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("break_release", 32'(busy), 32'(0));
        idle(10);

        send_frame("ff_rst", 8'hFF, 1'b1, ^8'hFF, 1, 4);
        idle(20);
        check_events("ff_rst");
        chk("ff_rst_data_out", 32'(data_out), 32'(0));
        send_frame("12", 8'h12, 1'b1, ^8'h12, 0, 0);
        idle(20);
        check_events("12");
        chk("12_data_out", 32'(data_out), 32'(8'h12));

        send_frame("55", 8'h55, 1'b1, ^8'h55, 0, 0);
        send_frame("aa", 8'hAA, 1'b1, ^8'hAA, 0, 0);
        idle(20);
        check_events("b2b");
        chk("b2b_data_out", 32'(data_out), 32'(8'hAA));

        send_frame("ena_abort", 8'h96, 1'b1, ^8'h96, 2, NB - 1);
        idle(20);
        check_events("ena_abort");
        chk("ena_data_out", 32'(data_out), 32'(8'hAA));

`ifdef UART_RX_PARITY_EN
        send_frame("par01", 8'h01, 1'b1, 1'b0, 0, 0);
        idle(20);
        check_events("par01");
        chk("par01_data_out", 32'(data_out), 32'(8'hAA));
`endif

        for (int k = 0; k < 8; k++) begin
            d      = 8'($urandom_range(0, 255));
            stop_b = ($urandom_range(0, 3) != 0);
            par_b  = (^d) ^ ($urandom_range(0, 3) == 0);
            send_frame("rand", d, stop_b, par_b, 0, 0);
            if (!stop_b) idle($urandom_range(2, 6));
            else idle($urandom_range(0, 4));
        end
        idle(30);
        check_events("rand");
        chk("rand_data_out", 32'(data_out), 32'(model_last));
        chk("rand_busy_after", 32'(busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal values are 4 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port ena, input, 1 bit: receiver enable; low aborts any frame and holds IDLE.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle-high.
REQ-006 The block SHALL have port data_out, output, 8 bits: last good received byte.
REQ-007 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_out is updated.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-009 The block SHALL have port parity_err, output, 1 bit: one-cycle pulse on parity mismatch (REQ-029).
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (rx_s) and its prior-cycle copy.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP (plus PARITY under REQ-029) and BREAK.
REQ-013 In IDLE with ena high, a rx_s 1->0 transition SHALL enter START and clear the bit-timer.
REQ-014 In START, after CLKS_PER_BIT/2 cycles (integer divide), rx_s low SHALL enter DATA; rx_s high SHALL be treated as a glitch and return to IDLE with no output pulse.
REQ-015 In DATA, rx_s SHALL be sampled every CLKS_PER_BIT cycles, 8 samples in total, shifted in LSB first; after the 8th sample the FSM goes to STOP.
REQ-016 In STOP, rx_s SHALL be sampled CLKS_PER_BIT cycles after the last data sample.
REQ-017 A high stop sample SHALL load data_out and pulse data_valid for exactly the next cycle, then return to IDLE.
REQ-018 A low stop sample SHALL pulse frame_err for one cycle, leave data_out unchanged, and enter BREAK.
REQ-019 BREAK SHALL stay until rx_s is high, then return to IDLE.
REQ-020 data_valid, frame_err and parity_err SHALL never be high for more than one consecutive cycle.
REQ-021 A new start edge SHALL be accepted in the first IDLE cycle after a frame ends, so back-to-back frames with a 1-bit stop are received without loss.
REQ-022 The bit-timer SHALL be the minimum width ($clog2 of CLKS_PER_BIT) and SHALL reload to 0 at each sample point.
REQ-023 ena low SHALL force IDLE on the next clock and cancel any pending pulse; data_out SHALL hold its value.
REQ-024 Latency SHALL be fixed: the data_valid pulse occurs 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx start edge at the pin.

Reset
REQ-025 On rst high at a clock edge, the state SHALL become IDLE, the bit-timer and bit index 0, and the shift register 0x00.
REQ-026 Under the same reset, data_out SHALL be 0x00; data_valid, frame_err, parity_err and busy SHALL be 0; the synchronizer flops SHALL be 1.
REQ-027 Reset asserted mid-frame SHALL discard the partial byte with no error pulse.
REQ-028 rst SHALL take priority over ena and rx.

Configuration
REQ-029 With macro UART_RX_PARITY_EN defined, an even-parity bit SHALL be sampled in state PARITY between DATA and STOP, one bit period after the last data bit.
REQ-030 When the parity bit does not equal the XOR of the 8 data bits, parity_err SHALL pulse with the stop-sample decision, and data_out/data_valid SHALL NOT be updated.
REQ-031 Without UART_RX_PARITY_EN, the frame SHALL be 8N1, state PARITY SHALL be absent, and parity_err SHALL be tied to 0.

Verification (CLKS_PER_BIT=16)
REQ-032 Send 0xA5, 8N1: data_out=0xA5 with a single-cycle data_valid at the REQ-024 latency; busy=0 afterwards.
REQ-033 Drive rx low for 4 cycles, then high: no pulse on any output, and busy returns to 0 within 12 cycles.
REQ-034 Send 0x3C, then 0x5A with stop bit low: first frame gives data_out=0x3C; second gives a frame_err pulse, data_out stays 0x3C and busy stays high until rx goes high.
REQ-035 Drive rst for one cycle during the 4th data bit of 0xFF, then send 0x12: outputs hold reset values, then data_out=0x12 with data_valid.
REQ-036 Send 0x55 and 0xAA back-to-back with no idle gap: two data_valid pulses, with values 0x55 then 0xAA.
REQ-037 With UART_RX_PARITY_EN, send 0x01 with parity bit 0: parity_err pulses once, data_valid stays 0, and data_out is unchanged.
